// File: rtl/rasterizer_vertex_store.sv
// Avalon-MM vertex buffer responder: DEPTH x 32-bit RAM, fixed-latency pipelined reads, byte-enabled writes.
// Optional macro RASTER_VSTORE_STALL_INJECT_EN adds LFSR-driven pseudo-random waitrequest stalls in READY.
module rasterizer_vertex_store #(
    parameter int unsigned DEPTH        = 1024,
    parameter logic [25:0] BASE_ADDR    = 26'h0,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [25:0] slave_address,
    input  logic        slave_read,
    input  logic        slave_write,
    input  logic [3:0]  slave_byteenable,
    input  logic [31:0] slave_writedata,
    output logic        slave_waitrequest,
    output logic [31:0] slave_readdata,
    output logic        slave_readdatavalid,
    output logic        init_done,
    output logic        proto_error,
    output logic        range_error,
    output logic [31:0] read_count,
    output logic [31:0] write_count
);
    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam logic [26:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [26:0] DEPTH_EXT = 27'(DEPTH);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state_r;
    logic [IDX_W-1:0]  clr_ptr_r;
    logic [31:0]       mem_r [DEPTH];
    logic              waitrequest_r;
    logic              init_done_r;
    logic              proto_error_r;
    logic              range_error_r;
    logic [31:0]       read_count_r;
    logic [31:0]       write_count_r;
    logic [READ_LATENCY-1:0] vld_pipe_r;
    logic [31:0]       data_pipe_r [READ_LATENCY];

    logic [26:0]       addr_ext_s;
    logic [26:0]       offset_s;
    logic [24:0]       word_off_s;
    logic [IDX_W-1:0]  idx_s;
    logic              in_range_s;
    logic              accept_s;
    logic              rd_acc_s;
    logic              wr_acc_s;
    logic              both_acc_s;
    logic              stall_s;
    logic              unused_s;

    // 27-bit arithmetic keeps BASE_ADDR + 4*DEPTH from wrapping; byte offset bits are don't-care.
    assign addr_ext_s = {1'b0, slave_address};
    assign offset_s   = addr_ext_s - BASE_EXT;
    assign word_off_s = offset_s[26:2];
    assign idx_s      = word_off_s[IDX_W-1:0];
    assign in_range_s = (addr_ext_s >= BASE_EXT) && ({2'b00, word_off_s} < DEPTH_EXT);
    assign unused_s   = ^offset_s[1:0];

    assign accept_s   = (slave_read | slave_write) & ~waitrequest_r & (state_r == ST_READY) & ~reset;
    assign rd_acc_s   = accept_s & slave_read;
    assign wr_acc_s   = accept_s & slave_write & ~slave_read;
    assign both_acc_s = accept_s & slave_read & slave_write;

`ifdef RASTER_VSTORE_STALL_INJECT_EN
    logic [15:0] lfsr_r;
    logic [15:0] lfsr_next_s;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    assign lfsr_next_s = lfsr_step(lfsr_r);
    // waitrequest is registered, so it is loaded from the LFSR value it will sit beside.
    assign stall_s     = (lfsr_next_s[1:0] == 2'b00);

    // Free-running stall pattern generator (x^16+x^14+x^13+x^11+1)
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= lfsr_next_s;
        end
    end
`else
    assign stall_s = 1'b0;
`endif

    // Control FSM: post-reset clear sequencing, handshake, error flags and access counters
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_INIT;
            clr_ptr_r     <= '0;
            waitrequest_r <= 1'b1;
            init_done_r   <= 1'b0;
            proto_error_r <= 1'b0;
            range_error_r <= 1'b0;
            read_count_r  <= 32'd0;
            write_count_r <= 32'd0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    waitrequest_r <= 1'b1;
                    if (clr_ptr_r == IDX_W'(DEPTH - 1)) begin
                        state_r       <= ST_READY;
                        init_done_r   <= 1'b1;
                        waitrequest_r <= stall_s;
                    end else begin
                        clr_ptr_r <= clr_ptr_r + IDX_W'(1);
                    end
                end
                ST_READY: begin
                    waitrequest_r <= stall_s;
                    if (rd_acc_s) begin
                        read_count_r <= read_count_r + 32'd1;
                    end
                    if (wr_acc_s) begin
                        write_count_r <= write_count_r + 32'd1;
                    end
                    if (both_acc_s) begin
                        proto_error_r <= 1'b1;
                    end
                    if (accept_s && !in_range_s) begin
                        range_error_r <= 1'b1;
                    end
                end
                default: begin
                    state_r       <= ST_INIT;
                    clr_ptr_r     <= '0;
                    waitrequest_r <= 1'b1;
                    init_done_r   <= 1'b0;
                end
            endcase
        end
    end

    // Vertex RAM: zero-fill during INIT, byte-lane writes afterwards
    always_ff @(posedge clock) begin
        if (state_r == ST_INIT) begin
            mem_r[clr_ptr_r] <= 32'h0;
        end else if (wr_acc_s && in_range_s) begin
            for (int b = 0; b < 4; b++) begin
                if (slave_byteenable[b]) begin
                    mem_r[idx_s][8*b +: 8] <= slave_writedata[8*b +: 8];
                end
            end
        end
    end

    // Read response pipeline; data stages only advance with a valid so readdata holds between strobes
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_pipe_r <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                data_pipe_r[i] <= 32'h0;
            end
        end else begin
            vld_pipe_r[0] <= rd_acc_s;
            if (rd_acc_s) begin
                data_pipe_r[0] <= in_range_s ? mem_r[idx_s] : 32'h0;
            end
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                vld_pipe_r[i] <= vld_pipe_r[i-1];
                if (vld_pipe_r[i-1]) begin
                    data_pipe_r[i] <= data_pipe_r[i-1];
                end
            end
        end
    end

    assign slave_waitrequest   = waitrequest_r;
    assign slave_readdata      = data_pipe_r[READ_LATENCY-1];
    assign slave_readdatavalid = vld_pipe_r[READ_LATENCY-1];
    assign init_done           = init_done_r;
    assign proto_error         = proto_error_r;
    assign range_error         = range_error_r;
    assign read_count          = read_count_r;
    assign write_count         = write_count_r;

endmodule

// File: doc/rasterizer_vertex_store.md
Name: rasterizer_vertex_store

Overview:
- Avalon-MM slave (responder) holding the vertex buffer in on-chip RAM; the responding end of the read/write master interface driven by the vertex fetch unit.
- Serves pipelined single-word reads at fixed latency and host/loader writes with per-byte enables.
- Clears memory after reset, flags protocol and range errors, and keeps access counters for debug.

Parameters:
- DEPTH, 1024, number of 32-bit words stored (power of 2).
- BASE_ADDR, 26'h0, byte address of word 0; accesses outside [BASE_ADDR, BASE_ADDR+4*DEPTH) are out of range.
- READ_LATENCY, 2, cycles from read accept to slave_readdatavalid (1..8).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- slave_address  in  26  byte address; bits [1:0] ignored.
- slave_read  in  1  read request.
- slave_write  in  1  write request.
- slave_byteenable  in  4  byte lanes for writes; ignored on reads.
- slave_writedata  in  32  write data.
- slave_waitrequest  out  1  request not accepted this cycle.
- slave_readdata  out  32  read data, valid with readdatavalid.
- slave_readdatavalid  out  1  one-cycle read response strobe.
- init_done  out  1  high once post-reset clear is complete.
- proto_error  out  1  sticky: read and write asserted together.
- range_error  out  1  sticky: out-of-range access accepted.
- read_count  out  32  accepted reads since reset, wraps.
- write_count  out  32  accepted writes since reset, wraps.

Behaviour:
- Reset (sync, active-high): state=INIT, clear pointer=0. Outputs: waitrequest=1, readdatavalid=0, readdata=0, init_done=0, both error flags=0, both counters=0. All in-flight reads are discarded; no readdatavalid issues for them.
- INIT: write 0 to word[ptr], ptr++ each cycle. waitrequest=1 throughout. Move to READY after word DEPTH-1, which takes DEPTH cycles.
- READY: init_done=1.
  - Without the optional feature, waitrequest=0.
  - An access is accepted in a cycle where (read|write) && !waitrequest.
- Index: (slave_address-BASE_ADDR)>>2.
  - In range iff address>=BASE_ADDR and index<DEPTH.
  - Range arithmetic uses 27 bits so BASE_ADDR+4*DEPTH cannot wrap.
- Accepted write:
  - Lanes with byteenable=1 update at the accept edge; other lanes are preserved.
  - write_count++.
  - Out of range: write dropped, range_error set.
- Accepted read:
  - Memory is sampled at the accept cycle T.
  - readdatavalid=1 with data at cycle T+READ_LATENCY, for exactly one cycle.
  - Out of range: returns 32'h0, range_error set, response still issued.
  - read_count++.
- Throughput and ordering:
  - Back-to-back reads are accepted every cycle.
  - Responses come in order, one per cycle, and cannot be backpressured.
  - Implemented as a READ_LATENCY-deep valid/data shift pipeline.
- Write then read of the same address in consecutive accepted cycles: the read returns the new data.
- A write accepted while earlier reads are in flight does not change those reads' data.
- Read and write both high in an accepted cycle: the read is performed, the write is ignored, proto_error set, write_count unchanged.
- readdata holds its last value when readdatavalid=0.
- Requests during INIT are stalled, not lost. Master must hold them per Avalon rules.

Optional Feature:
- Macro: RASTER_VSTORE_STALL_INJECT_EN.
- Defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) steps every cycle. In READY, waitrequest=1 whenever lfsr[1:0]==2'b00 (about 25% of cycles). This exercises the master's address/hold retry path.
  - Stall cycles accept nothing.
  - Responses already in flight are unaffected.
- Undefined: no LFSR; waitrequest=0 in READY.

Test Plan:
- Reset, then idle -> waitrequest=1 and init_done=0 for exactly DEPTH cycles. Then init_done=1; reads of index 0, 511 and 1023 return 0.
- Write 32'h11223344 to BASE_ADDR+8 with be=4'b1111, then be=4'b0101 with 32'hAABBCCDD -> read returns 32'h11BB33DD at accept+2; write_count=2, read_count=1.
- 16 back-to-back reads of words 0..15 (preloaded with value=index) -> 16 consecutive readdatavalid pulses starting at cycle T+2, with data 0..15 in order.
- Read BASE_ADDR+4*DEPTH -> response 32'h0 and range_error=1. Then read with write both high -> proto_error=1 and memory unchanged.
- Issue 3 reads, then reset on the next cycle -> no readdatavalid appears; INIT restarts with counters=0.
- With RASTER_VSTORE_STALL_INJECT_EN: 100 reads held under waitrequest -> exactly 100 responses with correct data and order, and read_count=100.
